// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiters.
// Holds the arbiter state encoding and the beat counter width helper.
package fifo_arb_pkg;

  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned BURST_LEN_DEF = 16;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  // Counter must be able to hold BURST_LEN itself, not just BURST_LEN-1.
  function automatic int unsigned cnt_w(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Produces the winner as one-hot and as an index, plus an any-request flag.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = IW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Grants one requester for up to BURST_LEN beats; stalls on almost_full/full.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic                      wr_clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      full,
  input  logic                      almost_full,
  input  logic                      wr_rst_busy,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      burst_done
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = cnt_w(BURST_LEN);

  arb_state_t        state, state_nx;
  logic [N_REQ-1:0]  gnt_nx;
  logic [IW-1:0]     g_idx, g_idx_nx;
  logic [CW-1:0]     beat_cnt, beat_cnt_nx;
  logic [IW-1:0]     rr_ptr, rr_ptr_nx;
  logic              wr_en_nx;
  logic [DATA_W-1:0] wr_data_nx;
  logic              done_nx;
  logic              ready_on;
  logic              accept;
  logic [DATA_W-1:0] g_data;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign ready_on = ~almost_full & ~full & ~wr_rst_busy;
  assign g_data   = req_data[32'(g_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    g_idx_nx    = g_idx;
    beat_cnt_nx = beat_cnt;
    rr_ptr_nx   = rr_ptr;
    wr_en_nx    = 1'b0;
    wr_data_nx  = fifo_wr_data;
    done_nx     = 1'b0;
    req_ready   = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (!wr_rst_busy && pick_any) begin
          state_nx    = BURST;
          gnt_nx      = pick_onehot;
          g_idx_nx    = pick_idx;
          beat_cnt_nx = '0;
        end
      end
      BURST: begin
        req_ready[g_idx] = ready_on;
        accept           = req_valid[g_idx] & ready_on;
        if (accept) begin
          wr_en_nx    = 1'b1;
          wr_data_nx  = g_data;
          beat_cnt_nx = CW'(beat_cnt + 1'b1);
        end
        // A beat accepted together with a dropped req is still written; the burst ends.
        if (wr_rst_busy || !req[g_idx] ||
            (accept && beat_cnt == CW'(BURST_LEN - 1))) begin
          state_nx  = IDLE;
          gnt_nx    = '0;
          done_nx   = 1'b1;
          rr_ptr_nx = (g_idx == IW'(N_REQ - 1)) ? '0 : IW'(g_idx + 1'b1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= '0;
      g_idx        <= '0;
      beat_cnt     <= '0;
      rr_ptr       <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      burst_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      gnt          <= gnt_nx;
      g_idx        <= g_idx_nx;
      beat_cnt     <= beat_cnt_nx;
      rr_ptr       <= rr_ptr_nx;
      fifo_wr_en   <= wr_en_nx;
      fifo_wr_data <= wr_data_nx;
      burst_done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus a random run, all checked
// cycle by cycle against a transaction-level owner/beat-count model.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_valid, req_ready, gnt;
  logic [N*DW-1:0] req_data;
  logic          full, af, busy;
  logic          fifo_wr_en, burst_done;
  logic [DW-1:0] fifo_wr_data;

  always #5 clk = ~clk;

  fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .wr_clk       (clk),
    .rst          (rst),
    .req          (req),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .gnt          (gnt),
    .full         (full),
    .almost_full  (af),
    .wr_rst_busy  (busy),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .burst_done   (burst_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, how many beats it has written, next start point.
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_ptr   = 0;
  logic          m_acc;
  logic [N-1:0]  e_gnt  = '0;
  logic          e_en   = 1'b0;
  logic [DW-1:0] e_data = '0;
  logic          e_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0;
      e_gnt = '0; e_en = 1'b0; e_data = '0; e_done = 1'b0;
    end else begin
      e_en = 1'b0;
      e_done = 1'b0;
      if (m_owner < 0) begin
        if (!busy && req != 0) begin
          for (int k = 0; k < N; k++)
            if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          m_beats = 0;
          e_gnt = N'(1) << m_owner;
        end
      end else begin
        m_acc = req_valid[m_owner] && !af && !full && !busy;
        if (m_acc) begin
          e_en = 1'b1;
          e_data = req_data[m_owner*DW +: DW];
          m_beats++;
        end
        if (busy || !req[m_owner] || m_beats == BL) begin
          e_done = 1'b1;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          e_gnt = '0;
        end
      end
    end
  end

  logic [2*N+DW+1:0] obs;
  assign obs = {gnt, fifo_wr_en, fifo_wr_data, burst_done, req_ready};

  function automatic logic [2*N+DW+1:0] expv();
    logic [N-1:0] r;
    r = (m_owner >= 0 && !af && !full && !busy) ? (N'(1) << m_owner) : '0;
    return {e_gnt, e_en, e_data, e_done, r};
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] v,
                       input logic a, input logic f, input logic b);
    req = r; req_valid = v; af = a; full = f; busy = b;
    req_data = $urandom;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('1, '1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt got %b want 0", gnt); end
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
    total++; if (fifo_wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got %h want 0", fifo_wr_data); end
    total++; if (burst_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", burst_done); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got %b want 0", req_ready); end
    rst = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    int writes = 0, dones = 0;
    apply_reset();
    for (int i = 0; i < 40 && dones == 0; i++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      if (burst_done) dones++;
      if (i == 1) begin
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt_latency got %b want 0010", gnt); end
      end
      drive((dones != 0) ? 4'b0000 : 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL single cyc%0d got %b want %b", i, obs, expv()); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      if (burst_done) dones++;
      drive('0, 4'b0010, 1'b0, 1'b0, 1'b0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL single_tail cyc%0d got %b want %b", i, obs, expv()); end
    end
    total++; if (writes != BL) begin bad++; $display("FAIL single_writes got %0d want %0d", writes, BL); end
    total++; if (dones != 1) begin bad++; $display("FAIL single_done got %0d want 1", dones); end
  endtask

  task automatic test_fairness();
    int order[$];
    int lens[$];
    int wr = 0, dones = 0;
    logic [N-1:0] prev = '0;
    apply_reset();
    for (int i = 0; i < 200 && dones < 5; i++) begin
      @(negedge clk);
      if (fifo_wr_en) wr++;
      if (burst_done) begin dones++; lens.push_back(wr); wr = 0; end
      if (gnt != 0 && prev == 0)
        for (int k = 0; k < N; k++) if (gnt[k]) order.push_back(k);
      prev = gnt;
      drive((dones >= 5) ? 4'b0000 : 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL fair cyc%0d got %b want %b", i, obs, expv()); end
    end
    total++;
    if (order.size() != 5 || lens.size() != 5) begin
      bad++; $display("FAIL fair_count got grants=%0d bursts=%0d want 5", order.size(), lens.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++; if (order[k] != k % N) begin bad++; $display("FAIL fair_order[%0d] got %0d want %0d", k, order[k], k % N); end
        total++; if (lens[k] != BL) begin bad++; $display("FAIL fair_len[%0d] got %0d want %0d", k, lens[k], BL); end
      end
    end
  endtask

  task automatic test_backpressure();
    int writes = 0, dones = 0, nstall = 0;
    logic a;
    apply_reset();
    for (int i = 0; i < 80 && dones == 0; i++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      if (burst_done) dones++;
      a = (writes >= 5 && nstall < 5);
      if (a) nstall++;
      drive((dones != 0) ? 4'b0000 : 4'b0001, 4'b0001, a, 1'b0, 1'b0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL bp cyc%0d got %b want %b", i, obs, expv()); end
      if (a) begin
        total++;
        if (req_ready !== '0 || gnt !== 4'b0001) begin
          bad++; $display("FAIL bp_stall got ready=%b gnt=%b want 0000/0001", req_ready, gnt);
        end
      end
    end
    total++; if (writes != BL) begin bad++; $display("FAIL bp_writes got %0d want %0d", writes, BL); end
    total++; if (nstall != 5) begin bad++; $display("FAIL bp_stalls got %0d want 5", nstall); end
  endtask

  task automatic test_release();
    int writes = 0, acc = 0;
    logic found = 1'b0;
    apply_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (gnt === 4'b1000) found = 1'b1;
      if (fifo_wr_en && !found) writes++;
      drive((acc >= 3) ? 4'b1000 : 4'b1100, (acc >= 3) ? 4'b1000 : 4'b0100, 1'b0, 1'b0, 1'b0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL rel cyc%0d got %b want %b", i, obs, expv()); end
      if (req_ready[2] && req_valid[2]) acc++;
    end
    total++; if (!found) begin bad++; $display("FAIL rel_next_grant got gnt=%b want 1000", gnt); end
    total++; if (writes != 3) begin bad++; $display("FAIL rel_writes got %0d want 3", writes); end
  endtask

  task automatic test_busy();
    int writes = 0, dones = 0;
    logic hit = 1'b0, b;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
      #1; total++;
      if (obs !== expv() || gnt !== '0) begin bad++; $display("FAIL busy_idle cyc%0d got %b want %b", i, obs, expv()); end
    end
    for (int i = 0; i < 60 && dones == 0; i++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      if (burst_done) dones++;
      b = (writes == 4 && !hit);
      if (b) hit = 1'b1;
      drive((dones != 0) ? 4'b0000 : 4'b0001, 4'b0001, 1'b0, 1'b0, b);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL busy cyc%0d got %b want %b", i, obs, expv()); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL busy_tail cyc%0d got %b want %b", i, obs, expv()); end
    end
    total++; if (writes != 4) begin bad++; $display("FAIL busy_writes got %0d want 4", writes); end
    total++; if (dones != 1) begin bad++; $display("FAIL busy_done got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    logic g = 1'b0, hit = 1'b0;
    apply_reset();
    // Leave the round-robin pointer at 1 so the post-reset grant shows it was cleared.
    for (int i = 0; i < 10 && !g; i++) begin
      @(negedge clk);
      if (gnt === 4'b0001) g = 1'b1;
      drive(g ? 4'b0000 : 4'b0001, '0, 1'b0, 1'b0, 1'b0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL rmid_pre cyc%0d got %b want %b", i, obs, expv()); end
    end
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      drive(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
      rst = (writes == 7);
      hit = rst;
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL rmid cyc%0d got %b want %b", i, obs, expv()); end
    end
    @(negedge clk);
    rst = 1'b0;
    total++; if (gnt !== '0 || fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rmid_cleared got gnt=%b en=%b want 0/0", gnt, fifo_wr_en); end
    drive(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    #1; total++;
    if (obs !== expv()) begin bad++; $display("FAIL rmid_post got %b want %b", obs, expv()); end
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rmid_first_grant got %b want 0001", gnt); end
    total++; if (!hit) begin bad++; $display("FAIL rmid_reached got writes=%0d want 7", writes); end
  endtask

  task automatic test_random();
    logic [N-1:0] r = '0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if ($urandom_range(7) == 0) r[k] = ~r[k];
      drive(r, N'($urandom), ($urandom_range(5) == 0), ($urandom_range(19) == 0),
            ($urandom_range(39) == 0));
      rst = ($urandom_range(499) == 0);
      #1; total++;
      if (obs !== expv()) begin bad++; $display("FAIL rand cyc%0d got %b want %b", i, obs, expv()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_release();
    test_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
